// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// keypad_scan_ctrl: 4x3 keypad row scanner with frame-level debounce, key-code FIFO and CPU interrupt.
// Define KEYPAD_REPEAT_EN to build the auto-repeat logic for held keys.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_RATE    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col,
  output logic [3:0] row,
  input  logic       rd_en,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic       interrupt,
  output logic       overflow
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(SCAN_DIV - 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, CAND = 2'd1, PRESSED = 2'd2} db_state_t;

  logic [2:0]    col_meta, col_sync;
  logic [SW-1:0] step_cnt;
  logic [1:0]    row_idx;
  logic          step_last, frame_end, frame_single;
  logic [1:0]    hits_acc, hits_next, samp_hits, col_idx;
  logic [2:0]    hits_total;
  logic [3:0]    code_acc, samp_code, frame_code;

  db_state_t     state, state_nx;
  logic [3:0]    cand, cand_nx;
  logic [DW-1:0] cnt, cnt_nx, rel, rel_nx;
  logic          accept_nx, rep_push, push_pend;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count, count_nx;
  logic          do_push, do_pop, drop;
  logic [7:0]    head_nx;

  function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r != 2'd3) begin
      code = 4'(r) * 4'd3 + 4'(c) + 4'd1;
    end else begin
      case (c)
        2'd0:    code = 4'hA;
        2'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 3'b000;
      col_sync <= 3'b000;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign step_last = (step_cnt == STEP_LAST);
  assign frame_end = step_last && (row_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      row_idx  <= 2'd0;
      row      <= 4'b0001;
    end else if (step_last) begin
      step_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      row      <= {row[2:0], row[3]};
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Whole-frame view: saturating hit count plus the code of the last single hit seen.
  always_comb begin
    samp_hits    = 2'(col_sync[0]) + 2'(col_sync[1]) + 2'(col_sync[2]);
    col_idx      = col_sync[2] ? 2'd2 : (col_sync[1] ? 2'd1 : 2'd0);
    samp_code    = encode(row_idx, col_idx);
    hits_total   = {1'b0, hits_acc} + {1'b0, samp_hits};
    hits_next    = (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
    frame_code   = (samp_hits == 2'd1) ? samp_code : code_acc;
    frame_single = frame_end && (hits_total == 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_acc <= 2'd0;
      code_acc <= 4'h0;
    end else if (frame_end) begin
      hits_acc <= 2'd0;
      code_acc <= 4'h0;
    end else if (step_last) begin
      hits_acc <= hits_next;
      code_acc <= frame_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      rel       <= '0;
      push_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      rel       <= rel_nx;
      push_pend <= accept_nx | rep_push;
    end
  end

  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    cnt_nx    = cnt;
    rel_nx    = rel;
    accept_nx = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (frame_single) begin
            cand_nx = frame_code;
            cnt_nx  = DW'(1);
            rel_nx  = '0;
            if (DEBOUNCE_SCANS == 1) begin
              state_nx  = PRESSED;
              accept_nx = 1'b1;
            end else begin
              state_nx = CAND;
            end
          end
        end
        CAND: begin
          if (frame_single && frame_code == cand) begin
            if (cnt + 1'b1 == DB_LAST) begin
              state_nx  = PRESSED;
              accept_nx = 1'b1;
              rel_nx    = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else if (frame_single) begin
            cand_nx = frame_code;
            cnt_nx  = DW'(1);
          end else begin
            state_nx = IDLE;
          end
        end
        PRESSED: begin
          // A different key only counts toward release; it is never accepted from here.
          if (frame_single && frame_code == cand) begin
            rel_nx = '0;
          end else if (rel + 1'b1 == DB_LAST) begin
            state_nx = IDLE;
            rel_nx   = '0;
          end else begin
            rel_nx = rel + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [RW-1:0] rep_cnt, rep_thr;
  logic          rep_phase, held;

  assign held     = frame_end && (state == PRESSED) && frame_single && (frame_code == cand);
  assign rep_thr  = rep_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
  assign rep_push = held && (rep_cnt + 1'b1 == rep_thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (frame_end) begin
      if (rep_push) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else if (held) begin
        rep_cnt <= rep_cnt + 1'b1;
      end else begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end
    end
  end
`else
  assign rep_push = 1'b0;
`endif

  assign do_pop  = rd_en && (count != '0);
  assign do_push = push_pend && ((count != FIFO_FULL) || do_pop);
  assign drop    = push_pend && (count == FIFO_FULL) && !do_pop;

  // Head is computed from the post-update FIFO so key_data tracks pops and first pushes immediately.
  always_comb begin
    count_nx  = count;
    if (do_push && !do_pop) count_nx = count + 1'b1;
    else if (!do_push && do_pop) count_nx = count - 1'b1;
    rd_ptr_nx = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    if (count_nx == '0) head_nx = 8'h00;
    else if (count == '0 || (do_pop && count == CW'(1))) head_nx = {4'h0, cand};
    else head_nx = mem[rd_ptr_nx];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {4'h0, cand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_data  <= 8'h00;
      key_valid <= 1'b0;
      interrupt <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_nx;
      count     <= count_nx;
      key_data  <= head_nx;
      key_valid <= (count_nx != '0);
      interrupt <= (count_nx != '0) && (!key_valid || do_pop) && !interrupt;
      if (do_pop) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
